// File: rtl/capture_sequencer.sv
// Multi-pulse lidar capture sequencer: keeps Fifo_TC at constant depth while armed,
// streams Sample_Num words per trigger into the accumulation buffer for Pulse_Num pulses.
module capture_sequencer #(
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Capture_En,
    input  logic             Trigger_Ready,
    input  logic             trigger_start,
    input  logic [CNT_W-1:0] Sample_Num,
    input  logic [CNT_W-1:0] Pulse_Num,
    output logic             Fifo_TC_Rd_En,
    output logic             Sample_Wr_En,
    output logic [CNT_W-1:0] Sample_Addr,
    output logic             First_Pulse,
    output logic [CNT_W-1:0] Pulse_Index,
    output logic [7:0]       Missed_Trig,
    output logic             Capture_Busy,
    output logic             Capture_Done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;

    logic [CNT_W-1:0] sample_num_q;
    logic [CNT_W-1:0] pulse_num_q;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] pulse_cnt;
    logic [7:0]       missed_q;

    logic             last_sample;
    logic             last_pulse;
    logic             latch_cfg;
    logic             start_pulse;
    logic             next_pulse;
    logic             strobe;
    logic             rd_en;
    logic             count_missed;

    // Write-side delay line matching the Fifo_TC read-to-data latency.
    logic [RD_LATENCY-1:0] wr_pipe;
    logic [RD_LATENCY-1:0] first_pipe;
    logic [CNT_W-1:0]      addr_pipe [RD_LATENCY];
    logic [CNT_W-1:0]      pidx_pipe [RD_LATENCY];

    assign last_sample = (sample_cnt == (sample_num_q - ONE));
    assign last_pulse  = (pulse_cnt == (pulse_num_q - ONE));

    // Triggers that cannot start a pulse while enabled are counted as missed.
    assign count_missed = trigger_start && Capture_En &&
                          ((state == CAPTURE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        rd_en       = 1'b0;
        strobe      = 1'b0;
        latch_cfg   = 1'b0;
        start_pulse = 1'b0;
        next_pulse  = 1'b0;
        case (state)
            IDLE: begin
                if (Capture_En) begin
                    state_next = ARMED;
                    latch_cfg  = 1'b1;
                end
            end
            ARMED: begin
                rd_en = Trigger_Ready;
                if (!Capture_En) begin
                    state_next = IDLE;
                end else if (trigger_start) begin
                    state_next  = CAPTURE;
                    start_pulse = 1'b1;
                end
            end
            CAPTURE: begin
                rd_en = 1'b1;
                if (!Capture_En) begin
                    state_next = IDLE;
                end else begin
                    strobe = 1'b1;
                    if (last_sample) begin
                        if (last_pulse) begin
                            state_next = DONE;
                        end else begin
                            state_next = ARMED;
                            next_pulse = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (!Capture_En) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Configuration is frozen for the whole accumulation; zero means one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_num_q <= ONE;
            pulse_num_q  <= ONE;
            sample_cnt   <= '0;
            pulse_cnt    <= '0;
        end else begin
            if (latch_cfg) begin
                sample_num_q <= (Sample_Num == '0) ? ONE : Sample_Num;
                pulse_num_q  <= (Pulse_Num == '0) ? ONE : Pulse_Num;
                pulse_cnt    <= '0;
            end else if (next_pulse) begin
                pulse_cnt <= pulse_cnt + ONE;
            end
            if (start_pulse) begin
                sample_cnt <= '0;
            end else if (strobe && !last_sample) begin
                sample_cnt <= sample_cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed_q <= '0;
        end else if (latch_cfg) begin
            missed_q <= '0;
        end else if (count_missed && (missed_q != 8'hFF)) begin
            missed_q <= missed_q + 8'd1;
        end
    end

    // Dropping Capture_En flushes every pending write so nothing lands after an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pipe    <= '0;
            first_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_pipe[i] <= '0;
                pidx_pipe[i] <= '0;
            end
        end else if (!Capture_En) begin
            wr_pipe    <= '0;
            first_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_pipe[i] <= '0;
                pidx_pipe[i] <= '0;
            end
        end else begin
            wr_pipe[0]    <= strobe;
            first_pipe[0] <= strobe && (pulse_cnt == '0);
            addr_pipe[0]  <= strobe ? sample_cnt : '0;
            pidx_pipe[0]  <= strobe ? pulse_cnt : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                wr_pipe[i]    <= wr_pipe[i-1];
                first_pipe[i] <= first_pipe[i-1];
                addr_pipe[i]  <= addr_pipe[i-1];
                pidx_pipe[i]  <= pidx_pipe[i-1];
            end
        end
    end

    assign Fifo_TC_Rd_En = rd_en;
    assign Sample_Wr_En  = wr_pipe[RD_LATENCY-1];
    assign First_Pulse   = first_pipe[RD_LATENCY-1];
    assign Sample_Addr   = addr_pipe[RD_LATENCY-1];
    assign Pulse_Index   = pidx_pipe[RD_LATENCY-1];
    assign Missed_Trig   = missed_q;
    assign Capture_Busy  = (state == ARMED) || (state == CAPTURE);
    assign Capture_Done  = (state == DONE) && (wr_pipe == '0);

endmodule
